ex_mem_reg: RTL and testbench
=============================

EX_MEM_REG -- requirements
Module: ex_mem_reg

Interface
REQ-001 Parameter DATA_W, default 16: width of ALU result and store-data fields.
REQ-002 clk  input  1  single clock; all state updates on rising edge.
REQ-003 rst  input  1  asynchronous, active-high reset.
REQ-004 stall  input  1  hold all EX/MEM contents this cycle.
REQ-005 flush  input  1  replace next contents with a bubble.
REQ-006 ex_valid  input  1  EX stage holds a real instruction.
REQ-007 ex_alu_result  input  DATA_W  ALU output or effective address.
REQ-008 ex_store_data  input  DATA_W  forwarded SrcReg2 value for stores.
REQ-009 ex_write_register / ex_src_reg2  input  4 each  destination / second source register ID.
REQ-010 ex_RegWrite, ex_MemtoReg, ex_MemWrite, ex_MemRead, ex_halt  input  1 each  EX control bits.
REQ-011 mem_* outputs: same names and widths as the ex_* inputs, registered, plus mem_valid  output  1.
REQ-012 halt_seen  output  1  sticky: a valid halt has reached MEM.

Function
REQ-013 Update priority, highest first: rst, flush, stall, load.
REQ-014 Load: with no stall or flush, every mem_* output takes its ex_* input on the clock edge; latency exactly 1 cycle.
REQ-015 Stall without flush: every mem_* output and halt_seen holds its value.
REQ-016 Flush, with or without stall: mem_valid, mem_RegWrite, mem_MemtoReg, mem_MemWrite, mem_MemRead and mem_halt go to 0; mem_write_register and mem_src_reg2 go to 0; data fields hold.
REQ-017 Load with ex_valid=0: the control bits listed in REQ-016 are forced to 0, so an invalid slot can never assert a write; register IDs and data still load.
REQ-018 Outputs are driven directly from flops, with no combinational path from input to output.
REQ-019 halt_seen: set on the edge where mem_valid and mem_halt are both 1 and flush=0; once set it stays set until rst.
REQ-020 After halt_seen=1, later loads are treated as ex_valid=0 and only bubbles enter.
REQ-021 Register ID 0 is not special-cased: mem_RegWrite=1 with mem_write_register=0 passes through unchanged.

Reset
REQ-022 Asserting rst clears all outputs to 0 immediately, without waiting for a clock edge: mem_valid=0, all control bits 0, IDs 0, data 0, halt_seen=0.
REQ-023 Deasserting rst: the first clock edge with rst=0 performs a normal REQ-013 update.
REQ-024 rst asserted mid-stall or mid-flush overrides both.

Configuration
REQ-025 Macro EXMEM_PERF_EN.
- Defined: adds output bubble_count (16 bits, reset 0).
  - Increments on each edge that loads a bubble, whether from flush or ex_valid=0.
  - Holds during stall and saturates at 0xFFFF.
- Undefined: port and counter are absent, and all other behaviour is identical.

Verification
REQ-026 Load: ex_valid=1, RegWrite=1, write_register=5, alu_result=0x1234 -> one edge later mem_valid=1, mem_write_register=5, mem_alu_result=0x1234.
REQ-027 Stall: contents A loaded, then stall=1 for 3 cycles with different inputs -> outputs stay A for all 3 cycles, and new inputs load on the first edge after stall=0.
REQ-028 Flush beats stall: stall=1 and flush=1 with MemWrite=1 held -> next edge gives mem_valid=0, mem_MemWrite=0, IDs 0.
REQ-029 Mid-cycle reset: rst pulsed high between edges while mem_RegWrite=1 -> outputs clear before the next edge, and halt_seen=0.
REQ-030 Halt: ex_halt=1 and ex_valid=1 loaded, then ex_valid=1 with RegWrite=1 offered -> halt_seen=1 on the following edge, then mem_RegWrite=0 on later loads.
REQ-031 EXMEM_PERF_EN defined: 2 flushes, 1 ex_valid=0 load, 2 stalls -> bubble_count=3; forced from 0xFFFF plus one flush -> stays 0xFFFF.

Source files
------------

// File: rtl/ex_mem_if.sv
// EX/MEM pipeline bus: EX-side inputs and control, registered MEM-side outputs.
// Latency: n/a (signal bundle only).
// Backpressure: stall/flush travel from master to the pipeline register.
// Ports: master drives ex_*, stall, flush and reads mem_*, halt_seen;
//        slave (the pipeline register) does the reverse.
// Optional: EXMEM_PERF_EN adds bubble_count (slave output).
interface ex_mem_if #(
  parameter int DATA_W = 16
);
  logic              stall;
  logic              flush;
  logic              ex_valid;
  logic [DATA_W-1:0] ex_alu_result;
  logic [DATA_W-1:0] ex_store_data;
  logic [3:0]        ex_write_register;
  logic [3:0]        ex_src_reg2;
  logic              ex_RegWrite;
  logic              ex_MemtoReg;
  logic              ex_MemWrite;
  logic              ex_MemRead;
  logic              ex_halt;

  logic              mem_valid;
  logic [DATA_W-1:0] mem_alu_result;
  logic [DATA_W-1:0] mem_store_data;
  logic [3:0]        mem_write_register;
  logic [3:0]        mem_src_reg2;
  logic              mem_RegWrite;
  logic              mem_MemtoReg;
  logic              mem_MemWrite;
  logic              mem_MemRead;
  logic              mem_halt;
  logic              halt_seen;
`ifdef EXMEM_PERF_EN
  logic [15:0]       bubble_count;
`endif

  modport master (
`ifdef EXMEM_PERF_EN
    input  bubble_count,
`endif
    output stall, flush, ex_valid, ex_alu_result, ex_store_data,
           ex_write_register, ex_src_reg2, ex_RegWrite, ex_MemtoReg,
           ex_MemWrite, ex_MemRead, ex_halt,
    input  mem_valid, mem_alu_result, mem_store_data, mem_write_register,
           mem_src_reg2, mem_RegWrite, mem_MemtoReg, mem_MemWrite,
           mem_MemRead, mem_halt, halt_seen
  );

  modport slave (
`ifdef EXMEM_PERF_EN
    output bubble_count,
`endif
    input  stall, flush, ex_valid, ex_alu_result, ex_store_data,
           ex_write_register, ex_src_reg2, ex_RegWrite, ex_MemtoReg,
           ex_MemWrite, ex_MemRead, ex_halt,
    output mem_valid, mem_alu_result, mem_store_data, mem_write_register,
           mem_src_reg2, mem_RegWrite, mem_MemtoReg, mem_MemWrite,
           mem_MemRead, mem_halt, halt_seen
  );
endinterface

// File: rtl/ex_mem_reg.sv
// EX/MEM pipeline register with flush-to-bubble and sticky halt detection.
// Latency: 1 cycle, all outputs straight from flops.
// Backpressure: stall holds everything; flush (wins over stall) inserts a bubble.
// Ports: clk, rst (async active-high), bus (ex_mem_if.slave).
// Optional: EXMEM_PERF_EN adds a saturating 16-bit bubble_count output.
module ex_mem_reg #(
  parameter int DATA_W = 16
) (
  input logic     clk,
  input logic     rst,
  ex_mem_if.slave bus
);

  typedef struct packed {
    logic reg_write;
    logic mem_to_reg;
    logic mem_write;
    logic mem_read;
    logic halt;
  } ctl_t;

  logic              valid_q, valid_d;
  ctl_t              ctl_q, ctl_d;
  logic [3:0]        wr_q, wr_d;
  logic [3:0]        src_q, src_d;
  logic [DATA_W-1:0] alu_q, alu_d;
  logic [DATA_W-1:0] sd_q, sd_d;
  logic              halt_seen_q, halt_seen_d;

  ctl_t ex_ctl;
  logic load;
  logic slot_valid;

  assign ex_ctl = '{reg_write:  bus.ex_RegWrite,
                    mem_to_reg: bus.ex_MemtoReg,
                    mem_write:  bus.ex_MemWrite,
                    mem_read:   bus.ex_MemRead,
                    halt:       bus.ex_halt};

  assign load = ~bus.flush & ~bus.stall;
  // Once a halt has retired into MEM, nothing behind it may do any work.
  assign slot_valid = bus.ex_valid & ~halt_seen_q;

  always_comb begin
    valid_d = valid_q;
    ctl_d   = ctl_q;
    wr_d    = wr_q;
    src_d   = src_q;
    alu_d   = alu_q;
    sd_d    = sd_q;
    if (bus.flush) begin
      // Bubble: kill control and IDs, leave the data fields alone.
      valid_d = 1'b0;
      ctl_d   = '0;
      wr_d    = '0;
      src_d   = '0;
    end else if (load) begin
      valid_d = slot_valid;
      ctl_d   = slot_valid ? ex_ctl : '0;
      wr_d    = bus.ex_write_register;
      src_d   = bus.ex_src_reg2;
      alu_d   = bus.ex_alu_result;
      sd_d    = bus.ex_store_data;
    end
  end

  // Only a load edge retires the halt currently sitting in MEM.
  assign halt_seen_d = halt_seen_q | (load & valid_q & ctl_q.halt);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      valid_q     <= 1'b0;
      ctl_q       <= '0;
      wr_q        <= '0;
      src_q       <= '0;
      alu_q       <= '0;
      sd_q        <= '0;
      halt_seen_q <= 1'b0;
    end else begin
      valid_q     <= valid_d;
      ctl_q       <= ctl_d;
      wr_q        <= wr_d;
      src_q       <= src_d;
      alu_q       <= alu_d;
      sd_q        <= sd_d;
      halt_seen_q <= halt_seen_d;
    end
  end

`ifdef EXMEM_PERF_EN
  logic [15:0] bubble_q, bubble_d;
  logic        bubble_in;

  // A bubble enters on a flush or on a load of an invalid (or post-halt) slot.
  assign bubble_in = bus.flush | (load & ~slot_valid);
  assign bubble_d  = (bubble_in && bubble_q != 16'hFFFF) ? bubble_q + 16'd1 : bubble_q;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) bubble_q <= '0;
    else     bubble_q <= bubble_d;
  end

  assign bus.bubble_count = bubble_q;
`endif

  assign bus.mem_valid          = valid_q;
  assign bus.mem_RegWrite       = ctl_q.reg_write;
  assign bus.mem_MemtoReg       = ctl_q.mem_to_reg;
  assign bus.mem_MemWrite       = ctl_q.mem_write;
  assign bus.mem_MemRead        = ctl_q.mem_read;
  assign bus.mem_halt           = ctl_q.halt;
  assign bus.mem_write_register = wr_q;
  assign bus.mem_src_reg2       = src_q;
  assign bus.mem_alu_result     = alu_q;
  assign bus.mem_store_data     = sd_q;
  assign bus.halt_seen          = halt_seen_q;

endmodule

// File: tb/tb_ex_mem_reg.sv
// Testbench for ex_mem_reg: directed vector table, mid-cycle reset, random vs. model.
// Latency: checks one cycle after each applied input.
// Backpressure: exercises stall, flush and both together.
module tb_ex_mem_reg;
  localparam int W = 16;

  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  ex_mem_if #(.DATA_W(W)) bus ();
  ex_mem_reg #(.DATA_W(W)) dut (.clk(clk), .rst(rst), .bus(bus));

  // ctl bit order: RegWrite, MemtoReg, MemWrite, MemRead, halt
  typedef struct packed {
    logic         stall;
    logic         flush;
    logic         v;
    logic [4:0]   ctl;
    logic [3:0]   wr;
    logic [3:0]   src;
    logic [W-1:0] alu;
    logic [W-1:0] sd;
  } in_t;

  typedef struct packed {
    logic         v;
    logic [4:0]   ctl;
    logic [3:0]   wr;
    logic [3:0]   src;
    logic [W-1:0] alu;
    logic [W-1:0] sd;
    logic         hs;
    logic [15:0]  bub;
  } st_t;

  typedef struct {
    in_t in;
    st_t exp;
  } vec_t;

  int n_tests = 0;
  int n_fail  = 0;
  st_t m;
  in_t cur;
  vec_t tbl[12];

  // Reference: what the MEM slot should contain after one edge.
  function automatic st_t model_step(st_t s, in_t i);
    st_t n = s;
    logic bubble;
    logic real_instr;
    real_instr = i.v && !s.hs;
    bubble = 1'b0;
    if (i.flush) begin
      n.v = 0; n.ctl = 0; n.wr = 0; n.src = 0;
      bubble = 1'b1;
    end else if (!i.stall) begin
      if (s.v && s.ctl[0]) n.hs = 1'b1;
      n.v   = real_instr;
      n.ctl = real_instr ? i.ctl : 5'd0;
      n.wr  = i.wr;
      n.src = i.src;
      n.alu = i.alu;
      n.sd  = i.sd;
      bubble = !real_instr;
    end
    if (bubble && n.bub != 16'hFFFF) n.bub = n.bub + 16'd1;
    return n;
  endfunction

  function automatic st_t observe();
    st_t o;
    o.v   = bus.mem_valid;
    o.ctl = {bus.mem_RegWrite, bus.mem_MemtoReg, bus.mem_MemWrite, bus.mem_MemRead, bus.mem_halt};
    o.wr  = bus.mem_write_register;
    o.src = bus.mem_src_reg2;
    o.alu = bus.mem_alu_result;
    o.sd  = bus.mem_store_data;
    o.hs  = bus.halt_seen;
`ifdef EXMEM_PERF_EN
    o.bub = bus.bubble_count;
`else
    o.bub = 16'd0;
`endif
    return o;
  endfunction

  task automatic check(input string name, input st_t exp);
    st_t o;
    st_t e;
    o = observe();
    e = exp;
`ifndef EXMEM_PERF_EN
    e.bub = 16'd0;
`endif
    n_tests++;
    if (o !== e) begin
      n_fail++;
      $display("FAIL %s: got v=%0b ctl=%05b wr=%0h src=%0h alu=%h sd=%h hs=%0b bub=%0d, want v=%0b ctl=%05b wr=%0h src=%0h alu=%h sd=%h hs=%0b bub=%0d",
               name, o.v, o.ctl, o.wr, o.src, o.alu, o.sd, o.hs, o.bub,
               e.v, e.ctl, e.wr, e.src, e.alu, e.sd, e.hs, e.bub);
    end
  endtask

  task automatic apply(input in_t i);
    bus.stall             = i.stall;
    bus.flush             = i.flush;
    bus.ex_valid          = i.v;
    bus.ex_RegWrite       = i.ctl[4];
    bus.ex_MemtoReg       = i.ctl[3];
    bus.ex_MemWrite       = i.ctl[2];
    bus.ex_MemRead        = i.ctl[1];
    bus.ex_halt           = i.ctl[0];
    bus.ex_write_register = i.wr;
    bus.ex_src_reg2       = i.src;
    bus.ex_alu_result     = i.alu;
    bus.ex_store_data     = i.sd;
  endtask

  // Reset pulse strictly between edges (called just after a negedge).
  task automatic midcycle_reset(input string name);
    #2 rst = 1'b1;
    #1 check(name, '0);
    rst = 1'b0;
    m = '0;
  endtask

  initial begin
    //            stall flush v  ctl       wr  src  alu       sd           v  ctl       wr src alu       sd       hs bub
    tbl[0]  = '{'{1'b0,1'b0,1'b1,5'b10000,4'd5,4'd3,16'h1234,16'h00AA}, '{1'b1,5'b10000,4'd5,4'd3,16'h1234,16'h00AA,1'b0,16'd0}};
    tbl[1]  = '{'{1'b1,1'b0,1'b1,5'b01110,4'd9,4'hA,16'hBEEF,16'h5555}, '{1'b1,5'b10000,4'd5,4'd3,16'h1234,16'h00AA,1'b0,16'd0}};
    tbl[2]  = '{'{1'b1,1'b0,1'b1,5'b01110,4'd9,4'hA,16'hBEEF,16'h5555}, '{1'b1,5'b10000,4'd5,4'd3,16'h1234,16'h00AA,1'b0,16'd0}};
    tbl[3]  = '{'{1'b1,1'b0,1'b0,5'b11111,4'd8,4'hB,16'hCAFE,16'h6666}, '{1'b1,5'b10000,4'd5,4'd3,16'h1234,16'h00AA,1'b0,16'd0}};
    tbl[4]  = '{'{1'b0,1'b0,1'b1,5'b01110,4'd9,4'hA,16'hBEEF,16'h5555}, '{1'b1,5'b01110,4'd9,4'hA,16'hBEEF,16'h5555,1'b0,16'd0}};
    tbl[5]  = '{'{1'b1,1'b1,1'b1,5'b00100,4'd7,4'd2,16'h1111,16'h2222}, '{1'b0,5'b00000,4'd0,4'd0,16'hBEEF,16'h5555,1'b0,16'd1}};
    tbl[6]  = '{'{1'b0,1'b0,1'b0,5'b11110,4'd6,4'd4,16'h3333,16'h4444}, '{1'b0,5'b00000,4'd6,4'd4,16'h3333,16'h4444,1'b0,16'd2}};
    tbl[7]  = '{'{1'b0,1'b0,1'b1,5'b10000,4'd0,4'd0,16'h0042,16'h0000}, '{1'b1,5'b10000,4'd0,4'd0,16'h0042,16'h0000,1'b0,16'd2}};
    tbl[8]  = '{'{1'b0,1'b0,1'b1,5'b00001,4'd1,4'd1,16'h0000,16'h0000}, '{1'b1,5'b00001,4'd1,4'd1,16'h0000,16'h0000,1'b0,16'd2}};
    tbl[9]  = '{'{1'b0,1'b0,1'b1,5'b10000,4'd2,4'd3,16'h0007,16'h0008}, '{1'b1,5'b10000,4'd2,4'd3,16'h0007,16'h0008,1'b1,16'd2}};
    tbl[10] = '{'{1'b0,1'b0,1'b1,5'b10000,4'd4,4'd5,16'h0009,16'h000A}, '{1'b0,5'b00000,4'd4,4'd5,16'h0009,16'h000A,1'b1,16'd3}};
    tbl[11] = '{'{1'b0,1'b1,1'b1,5'b10100,4'd6,4'd6,16'h0001,16'h0002}, '{1'b0,5'b00000,4'd0,4'd0,16'h0009,16'h000A,1'b1,16'd4}};

    apply('0);
    #2 check("reset_async", '0);
    @(posedge clk);
    @(negedge clk);
    check("reset_held", '0);
    rst = 1'b0;

    for (int k = 0; k < 12; k++) begin
      apply(tbl[k].in);
      @(posedge clk);
      @(negedge clk);
      check($sformatf("vec%0d", k), tbl[k].exp);
    end

    // Reset between edges clears halt_seen, then again while RegWrite is live.
    midcycle_reset("midrst_halt");
    cur = '{1'b0,1'b0,1'b1,5'b10000,4'd3,4'd1,16'h00F0,16'h000F};
    apply(cur);
    @(posedge clk);
    @(negedge clk);
    check("rst_release_load", '{1'b1,5'b10000,4'd3,4'd1,16'h00F0,16'h000F,1'b0,16'd0});
    apply('{1'b1,1'b1,1'b1,5'b10100,4'd3,4'd1,16'h00F0,16'h000F});
    midcycle_reset("midrst_flush_stall");

    // Random traffic against the model, with occasional mid-cycle resets.
    m = '0;
    for (int c = 0; c < 600; c++) begin
      cur.stall = ($urandom_range(0, 3) == 0);
      cur.flush = ($urandom_range(0, 7) == 0);
      cur.v     = ($urandom_range(0, 3) != 0);
      cur.ctl   = {$urandom_range(0, 15) == 0 ? 1'b1 : 1'b0, 4'($urandom_range(0, 15))};
      cur.ctl   = {cur.ctl[3:0], cur.ctl[4]};
      cur.wr    = 4'($urandom);
      cur.src   = 4'($urandom);
      cur.alu   = W'($urandom);
      cur.sd    = W'($urandom);
      apply(cur);
      if ($urandom_range(0, 49) == 0) midcycle_reset($sformatf("rand_rst%0d", c));
      @(posedge clk);
      m = model_step(m, cur);
      @(negedge clk);
      check($sformatf("rand%0d", c), m);
    end

`ifdef EXMEM_PERF_EN
    // Saturation: counter preset to its ceiling must not wrap on a bubble.
    force dut.bubble_q = 16'hFFFF;
    #1 release dut.bubble_q;
    apply('{1'b0,1'b1,1'b0,5'b00000,4'd0,4'd0,16'h0,16'h0});
    @(posedge clk);
    @(negedge clk);
    n_tests++;
    if (bus.bubble_count !== 16'hFFFF) begin
      n_fail++;
      $display("FAIL bubble_sat: got %h want ffff", bus.bubble_count);
    end
`endif

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end
endmodule
